// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        FREEZE = 2'd2,
        ERROR  = 2'd3
    } state_e;

    localparam logic [1:0]  WB_SRC_ALU = 2'b00;
    localparam logic [1:0]  WB_SRC_MEM = 2'b01;
    localparam logic [1:0]  WB_SRC_PC4 = 2'b10;

    // addi x0, x0, 0 -- what the FE/DE register holds after a flush
    localparam logic [31:0] NOP_INSN   = 32'h00000013;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the DE operands and the EX destination.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_de_i,
    input  logic [4:0] rs2_de_i,
    input  logic       rs1_used_de_i,
    input  logic       rs2_used_de_i,
    input  logic [4:0] rd_ex_i,
    input  logic       ruwr_ex_i,
    input  logic [1:0] wbsrc_ex_i,
    input  logic       valid_ex_i,
    output logic       load_use_o
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        // x0 never carries a value, and a bubble in EX never blocks DE
        ex_is_load = valid_ex_i & ruwr_ex_i & (wbsrc_ex_i == WB_SRC_MEM) & (rd_ex_i != 5'd0);
        rs1_hit    = rs1_used_de_i & (rs1_de_i == rd_ex_i);
        rs2_hit    = rs2_used_de_i & (rs2_de_i == rd_ex_i);
        load_use_o = ex_is_load & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: enables, flushes, valid bits
// and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MAX_FREEZE = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             rs1_used_de,
    input  logic             rs2_used_de,
    input  logic [4:0]       rd_ex,
    input  logic             RuWr_ex,
    input  logic [1:0]       RUDataWrSrc_ex,
    input  logic             NextPCSrc,
    input  logic             dm_busy,
    output logic             pc_en,
    output logic             de_en,
    output logic             de_flush,
    output logic             ex_en,
    output logic             ex_flush,
    output logic             me_en,
    output logic             wb_en,
    output logic             valid_de,
    output logic             valid_ex,
    output logic             valid_me,
    output logic             valid_wb,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int FRZ_W = $clog2(MAX_FREEZE + 1);

    state_e           state_q, state_d;
    logic [FRZ_W-1:0] frz_q, frz_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             vde_q, vex_q, vme_q, vwb_q;
    logic             load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    hazard_detect u_hazard (
        .rs1_de_i      (rs1_de),
        .rs2_de_i      (rs2_de),
        .rs1_used_de_i (rs1_used_de),
        .rs2_used_de_i (rs2_used_de),
        .rd_ex_i       (rd_ex),
        .ruwr_ex_i     (RuWr_ex),
        .wbsrc_ex_i    (RUDataWrSrc_ex),
        .valid_ex_i    (vex_q),
        .load_use_o    (load_use)
    );

    always_comb begin
        state_d  = state_q;
        frz_d    = frz_q;
        stall_d  = stall_q;
        flush_d  = flush_q;
        pc_en    = 1'b0;
        de_en    = 1'b0;
        de_flush = 1'b0;
        ex_en    = 1'b0;
        ex_flush = 1'b0;
        me_en    = 1'b0;
        wb_en    = 1'b0;

        case (state_q)
            BOOT: state_d = RUN;
            // FREEZE with memory ready behaves exactly like RUN in that cycle
            RUN, FREEZE: begin
                if (dm_busy) begin
                    frz_d   = (state_q == RUN) ? FRZ_W'(1) : frz_q + 1'b1;
                    state_d = (frz_d >= FRZ_W'(MAX_FREEZE)) ? ERROR : FREEZE;
                end else begin
                    state_d = RUN;
                    pc_en   = 1'b1;
                    de_en   = 1'b1;
                    ex_en   = 1'b1;
                    me_en   = 1'b1;
                    wb_en   = 1'b1;
                    if (NextPCSrc) begin
                        de_flush = 1'b1;
                        ex_flush = 1'b1;
                        flush_d  = sat_inc(flush_q);
                    end else if (load_use) begin
                        pc_en    = 1'b0;
                        de_en    = 1'b0;
                        ex_flush = 1'b1;
                        stall_d  = sat_inc(stall_q);
                    end
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = BOOT;
        endcase

        if (rst) begin
            pc_en    = 1'b0;
            de_en    = 1'b0;
            de_flush = 1'b0;
            ex_en    = 1'b0;
            ex_flush = 1'b0;
            me_en    = 1'b0;
            wb_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            frz_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
            vde_q   <= 1'b0;
            vex_q   <= 1'b0;
            vme_q   <= 1'b0;
            vwb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frz_q   <= frz_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            if (de_en) vde_q <= ~de_flush;
            if (ex_en) vex_q <= vde_q & ~ex_flush;
            if (me_en) vme_q <= vex_q;
            if (wb_en) vwb_q <= vme_q;
        end
    end

    assign valid_de    = vde_q;
    assign valid_ex    = vex_q;
    assign valid_me    = vme_q;
    assign valid_wb    = vwb_q;
    assign mem_timeout = (state_q == ERROR);
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl with hand sequences
// for reset, bubble, saturation, freeze and timeout behaviour.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W      = 4;
    localparam int MAX_FREEZE = 64;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    // enable vector order: {pc_en, de_en, de_flush, ex_en, ex_flush, me_en, wb_en}
    localparam logic [6:0] EN_NONE  = 7'b0000000;
    localparam logic [6:0] EN_RUN   = 7'b1101011;
    localparam logic [6:0] EN_STALL = 7'b0001111;
    localparam logic [6:0] EN_FLUSH = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [4:0]       rs1_de, rs2_de, rd_ex;
    logic             rs1_used_de, rs2_used_de, RuWr_ex;
    logic [1:0]       RUDataWrSrc_ex;
    logic             NextPCSrc, dm_busy;
    logic             pc_en, de_en, de_flush, ex_en, ex_flush, me_en, wb_en;
    logic             valid_de, valid_ex, valid_me, valid_wb, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_FREEZE(MAX_FREEZE)) dut (
        .clk(clk), .rst(rst),
        .rs1_de(rs1_de), .rs2_de(rs2_de),
        .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de),
        .rd_ex(rd_ex), .RuWr_ex(RuWr_ex), .RUDataWrSrc_ex(RUDataWrSrc_ex),
        .NextPCSrc(NextPCSrc), .dm_busy(dm_busy),
        .pc_en(pc_en), .de_en(de_en), .de_flush(de_flush),
        .ex_en(ex_en), .ex_flush(ex_flush), .me_en(me_en), .wb_en(wb_en),
        .valid_de(valid_de), .valid_ex(valid_ex), .valid_me(valid_me), .valid_wb(valid_wb),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    wire [6:0] en_vec = {pc_en, de_en, de_flush, ex_en, ex_flush, me_en, wb_en};
    wire [3:0] vld    = {valid_de, valid_ex, valid_me, valid_wb};

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, ruwr, npc;
        logic [1:0] src;
        logic [6:0] exp_en;
        int         exp_stall_inc, exp_flush_inc;
        logic       exp_vex;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   passed = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_de = 5'd0; rs2_de = 5'd0; rd_ex = 5'd0;
        rs1_used_de = 1'b0; rs2_used_de = 1'b0; RuWr_ex = 1'b0;
        RUDataWrSrc_ex = WB_SRC_ALU; NextPCSrc = 1'b0; dm_busy = 1'b0;
    endtask

    task automatic load_use_inputs();
        rd_ex = 5'd5; RuWr_ex = 1'b1; RUDataWrSrc_ex = WB_SRC_MEM;
        rs1_de = 5'd5; rs1_used_de = 1'b1; rs2_de = 5'd0; rs2_used_de = 1'b0;
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic ruwr,
                                input logic [1:0] src, input logic npc, input logic [6:0] e,
                                input int si, input int fi, input logic vx);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd; v.ruwr = ruwr;
        v.src = src; v.npc = npc; v.exp_en = e;
        v.exp_stall_inc = si; v.exp_flush_inc = fi; v.exp_vex = vx;
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        $display("pipeline_hazard_ctrl bench, flush NOP = %h", NOP_INSN);
        vecs[0] = mk(5'd1, 1, 5'd2, 1, 5'd3, 1, WB_SRC_MEM, 0, EN_RUN,   0, 0, 1);
        vecs[1] = mk(5'd5, 1, 5'd0, 0, 5'd5, 1, WB_SRC_MEM, 0, EN_STALL, 1, 0, 0);
        vecs[2] = mk(5'd0, 0, 5'd7, 1, 5'd7, 1, WB_SRC_MEM, 0, EN_STALL, 1, 0, 0);
        vecs[3] = mk(5'd0, 1, 5'd0, 1, 5'd0, 1, WB_SRC_MEM, 0, EN_RUN,   0, 0, 1);
        vecs[4] = mk(5'd1, 1, 5'd9, 0, 5'd9, 1, WB_SRC_MEM, 0, EN_RUN,   0, 0, 1);
        vecs[5] = mk(5'd5, 1, 5'd0, 0, 5'd5, 1, WB_SRC_ALU, 0, EN_RUN,   0, 0, 1);
        vecs[6] = mk(5'd5, 1, 5'd0, 0, 5'd5, 0, WB_SRC_MEM, 0, EN_RUN,   0, 0, 1);
        vecs[7] = mk(5'd5, 1, 5'd0, 0, 5'd5, 1, WB_SRC_PC4, 0, EN_RUN,   0, 0, 1);
        vecs[8] = mk(5'd1, 0, 5'd2, 0, 5'd3, 0, WB_SRC_ALU, 1, EN_FLUSH, 0, 1, 0);
        vecs[9] = mk(5'd5, 1, 5'd0, 0, 5'd5, 1, WB_SRC_MEM, 1, EN_FLUSH, 0, 1, 0);

        // reset held for two edges, then BOOT, then RUN filling the valid pipe
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("en during rst", 32'(en_vec), 32'(EN_NONE));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("boot en", 32'(en_vec), 32'(EN_NONE));
        chk("boot valid", 32'(vld), 32'h0);
        chk("boot stall_cnt", 32'(stall_cnt), 32'h0);
        chk("boot flush_cnt", 32'(flush_cnt), 32'h0);
        chk("boot mem_timeout", 32'(mem_timeout), 32'h0);
        tick();
        @(negedge clk);
        chk("run1 en", 32'(en_vec), 32'(EN_RUN));
        chk("run1 valid", 32'(vld), 32'h0);
        tick();
        chk("run2 valid", 32'(vld), 32'b1000);
        tick();
        chk("run3 valid", 32'(vld), 32'b1100);
        tick();
        chk("run4 valid", 32'(vld), 32'b1110);
        tick();
        chk("valid_wb after 4th run edge", 32'(vld), 32'b1111);
        chk("idle stall_cnt", 32'(stall_cnt), 32'h0);
        chk("idle flush_cnt", 32'(flush_cnt), 32'h0);

        // single-cycle events applied to a full pipeline, two refill cycles between
        for (int i = 0; i < 10; i++) begin
            rs1_de = vecs[i].rs1; rs1_used_de = vecs[i].u1;
            rs2_de = vecs[i].rs2; rs2_used_de = vecs[i].u2;
            rd_ex = vecs[i].rd; RuWr_ex = vecs[i].ruwr;
            RUDataWrSrc_ex = vecs[i].src; NextPCSrc = vecs[i].npc;
            @(negedge clk);
            chk($sformatf("vec%0d en", i), 32'(en_vec), 32'(vecs[i].exp_en));
            tick();
            exp_stall += vecs[i].exp_stall_inc;
            exp_flush += vecs[i].exp_flush_inc;
            chk($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt), 32'(exp_stall));
            chk($sformatf("vec%0d flush_cnt", i), 32'(flush_cnt), 32'(exp_flush));
            chk($sformatf("vec%0d valid_ex", i), 32'(valid_ex), 32'(vecs[i].exp_vex));
            if (vecs[i].npc) chk($sformatf("vec%0d valid_de", i), 32'(valid_de), 32'h0);
            idle_inputs();
            tick();
            tick();
        end

        // a hazard against the bubbles left by a flush must not stall
        NextPCSrc = 1'b1;
        tick();
        exp_flush = sat(exp_flush);
        NextPCSrc = 1'b0;
        load_use_inputs();
        @(negedge clk);
        chk("bubble1 no stall", 32'(en_vec), 32'(EN_RUN));
        tick();
        @(negedge clk);
        chk("bubble2 no stall", 32'(en_vec), 32'(EN_RUN));
        tick();
        chk("bubble stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        @(negedge clk);
        chk("refilled ex stalls", 32'(en_vec), 32'(EN_STALL));
        tick();
        exp_stall = sat(exp_stall);
        chk("refilled stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        idle_inputs();
        tick();

        // counter saturation
        NextPCSrc = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_flush = sat(exp_flush);
        end
        chk("flush_cnt saturated", 32'(flush_cnt), 32'(exp_flush));
        idle_inputs();
        tick();
        tick();
        for (int k = 0; k < 20; k++) begin
            load_use_inputs();
            tick();
            exp_stall = sat(exp_stall);
            idle_inputs();
            tick();
        end
        chk("stall_cnt saturated", 32'(stall_cnt), 32'(exp_stall));
        chk("flush_cnt held", 32'(flush_cnt), 32'(exp_flush));

        // three-cycle memory wait on a full pipeline
        tick(); tick(); tick(); tick();
        dm_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("freeze%0d en", k), 32'(en_vec), 32'(EN_NONE));
            chk($sformatf("freeze%0d valid", k), 32'(vld), 32'b1111);
            tick();
        end
        dm_busy = 1'b0;
        @(negedge clk);
        chk("unfreeze en", 32'(en_vec), 32'(EN_RUN));
        chk("unfreeze valid", 32'(vld), 32'b1111);
        chk("unfreeze mem_timeout", 32'(mem_timeout), 32'h0);
        tick();
        chk("resume valid", 32'(vld), 32'b1111);
        chk("freeze stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // memory wait long enough to time out
        dm_busy = 1'b1;
        for (int k = 1; k <= MAX_FREEZE; k++) begin
            tick();
            if (k == MAX_FREEZE - 1) chk("pre-timeout mem_timeout", 32'(mem_timeout), 32'h0);
        end
        chk("timeout mem_timeout", 32'(mem_timeout), 32'h1);
        @(negedge clk);
        chk("timeout en", 32'(en_vec), 32'(EN_NONE));
        dm_busy = 1'b0;
        NextPCSrc = 1'b1;
        @(negedge clk);
        chk("error en stuck", 32'(en_vec), 32'(EN_NONE));
        tick();
        chk("error sticky", 32'(mem_timeout), 32'h1);

        // reset recovers from ERROR
        rst = 1'b1;
        @(negedge clk);
        chk("error rst en", 32'(en_vec), 32'(EN_NONE));
        tick();
        rst = 1'b0;
        NextPCSrc = 1'b0;
        chk("rst clears mem_timeout", 32'(mem_timeout), 32'h0);
        chk("rst clears stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst clears flush_cnt", 32'(flush_cnt), 32'h0);
        chk("rst clears valid", 32'(vld), 32'h0);
        @(negedge clk);
        chk("reboot en", 32'(en_vec), 32'(EN_NONE));
        tick();
        @(negedge clk);
        chk("rerun en", 32'(en_vec), 32'(EN_RUN));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
